// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store interface stage between execute and the data-memory bus.
// Runs each core request as a valid/ready bus transaction, stalls the core while
// it is outstanding and returns load data with a one-cycle resp_valid pulse.
// Optional feature macro: LSU_TIMEOUT_EN (aborts a stuck REQ/WAIT after
// TIMEOUT_CYCLES cycles and flags resp_err).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; a request is latched and stalls the core
// REQ   | dmem_valid high, bus attributes held until dmem_ready
// WAIT  | read accepted, waiting for dmem_rvalid
// DONE  | resp_valid pulse; core released and advances on this edge
module lsu_mem_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_r_en,
    input  logic                  req_w_en,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  dmem_valid,
    input  logic                  dmem_ready,
    output logic                  dmem_wen,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  timeout_hit;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;

    // Counting includes the current cycle, so the abort fires at the end of
    // the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_LIMIT);

    // Cycle counter: held at zero in IDLE so it is clear on entry to REQ.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = 8'd0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_d = cnt_inc;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // Next-state, latched bus attributes, load capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        stall      = 1'b0;
        dmem_valid = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (req_r_en || req_w_en) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wen_d   = req_w_en;   // write wins when both are raised
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall      = 1'b1;
                dmem_valid = 1'b1;
                if (dmem_ready) begin
                    state_d = wen_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wen   = wen_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed testbench for lsu_mem_if with a bus/response scoreboard.
// Build with +define+LSU_TIMEOUT_EN to exercise the timeout abort path.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_r_en, req_w_en;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        dmem_valid, dmem_ready, dmem_wen;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    lsu_mem_if #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_r_en   (req_r_en),
        .req_w_en   (req_w_en),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    bus_t        exp_bus[$];
    resp_t       exp_resp[$];
    bus_t        b_item;
    resp_t       r_item;
    logic [31:0] last_load = 32'h0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Bus-side and response-side scoreboard, sampled mid-cycle.
    logic        pend = 1'b0;
    logic        pend_wen;
    logic [31:0] pend_addr, pend_wdata;

    always @(negedge clk) begin
        if (dmem_valid && pend) begin
            chk("addr_stable", dmem_addr, pend_addr);
            chk("wdata_stable", dmem_wdata, pend_wdata);
            chk("wen_stable", 32'(dmem_wen), 32'(pend_wen));
        end
        pend       = dmem_valid && !dmem_ready;
        pend_addr  = dmem_addr;
        pend_wdata = dmem_wdata;
        pend_wen   = dmem_wen;
        if (dmem_valid && dmem_ready) begin
            chk("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
            if (exp_bus.size() != 0) begin
                b_item = exp_bus.pop_front();
                chk("bus_wen", 32'(dmem_wen), 32'(b_item.wen));
                chk("bus_addr", dmem_addr, b_item.addr);
                chk("bus_wdata", dmem_wdata, b_item.wdata);
            end
        end
        if (resp_valid) begin
            chk("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
            if (exp_resp.size() != 0) begin
                r_item = exp_resp.pop_front();
                chk("resp_rdata", resp_rdata, r_item.rdata);
                chk("resp_err", 32'(resp_err), 32'(r_item.err));
            end
        end else begin
            chk("resp_err_idle", 32'(resp_err), 32'd0);
        end
    end

    // One core access plus a bus responder; starts and ends just after a rising edge.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rd, input bit noise, input bit exp_timeout,
                          input int exp_lat, input string tag);
        int cyc = 0;
        int vcnt = 0;
        int wcnt = 0;
        bit in_wait = 1'b0;
        bit done = 1'b0;
        req_w_en  = w;
        req_r_en  = r;
        req_addr  = a;
        req_wdata = wd;
        if (exp_timeout) begin
            exp_resp.push_back('{32'h0, 1'b1});
            last_load = 32'h0;
        end else begin
            exp_bus.push_back('{w, a, wd});
            exp_resp.push_back('{(w ? last_load : rd), 1'b0});
            if (!w) last_load = rd;
        end
        while (!done && cyc < 200) begin
            dmem_ready  = dmem_valid && (vcnt >= rdy_dly);
            if (dmem_valid) vcnt++;
            dmem_rvalid = in_wait ? (wcnt >= rv_dly) : noise;
            dmem_rdata  = (in_wait && wcnt >= rv_dly) ? rd : (32'hBAD0_0000 | 32'(cyc));
            if (in_wait) wcnt++;
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
                chk({tag, "_valid_idle"}, 32'(dmem_valid), 32'd0);
            end
            if (dmem_valid && dmem_ready && !dmem_wen) in_wait = 1'b1;
            else if (in_wait && dmem_rvalid) in_wait = 1'b0;
            if (resp_valid) begin
                done = 1'b1;
                chk({tag, "_stall_done"}, 32'(stall), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_latency"}, done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({tag, "_valid_cycles"}, 32'(vcnt), exp_timeout ? 32'd4 : 32'(rdy_dly + 1));
        req_r_en    = 1'b0;
        req_w_en    = 1'b0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        rst         = 1'b0;
        req_r_en    = 1'b0;
        req_w_en    = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        // reset state
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dmem_valid", 32'(dmem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wen", 32'(dmem_wen), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // store, immediate ready: resp_valid in the 3rd cycle
        access(1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, 1'b0, 3, "store");
        // load, ready after 2 cycles, rvalid 3 cycles later, stray rvalid outside WAIT
        access(1'b0, 1'b1, 32'h8000_0020, 32'h0000_1111, 2, 3, 32'h1234_5678, 1'b1, 1'b0, 9, "load_slow");
        // both enables: the write is issued
        access(1'b1, 1'b1, 32'h8000_0030, 32'hA5A5_5A5A, 0, 0, 32'h0, 1'b0, 1'b0, 3, "both_en");
        // back-to-back loads held across DONE
        access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 4, "b2b_first");
        access(1'b0, 1'b1, 32'h0000_0104, 32'h0, 0, 0, 32'h7654_3210, 1'b0, 1'b0, 4, "b2b_second");

        // reset while in WAIT
        req_r_en   = 1'b1;
        req_addr   = 32'h8000_0040;
        req_wdata  = 32'h0;
        dmem_ready = 1'b1;
        exp_bus.push_back('{1'b0, 32'h8000_0040, 32'h0});
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1 dmem_ready = 1'b0;
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_dmem_valid", 32'(dmem_valid), 32'd0);
        #1 rst = 1'b0;
        req_r_en  = 1'b0;
        last_load = 32'h0;
        #1;
        chk("abort_dmem_valid", 32'(dmem_valid), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 dmem_rvalid = 1'b1;
            dmem_rdata = 32'hCAFE_F00D;
            @(negedge clk);
            chk("late_rvalid_resp", 32'(resp_valid), 32'd0);
            chk("late_rvalid_rdata", resp_rdata, 32'd0);
            chk("late_rvalid_stall", 32'(stall), 32'd0);
        end
        @(posedge clk);
        #1 dmem_rvalid = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // bus never ready: abort after 4 REQ cycles with resp_err
        access(1'b0, 1'b1, 32'h8000_0050, 32'h0, 1000, 0, 32'h5555_5555, 1'b0, 1'b1, 6, "timeout");
`else
        // bus never ready: stall held indefinitely
        req_r_en = 1'b1;
        req_addr = 32'h8000_0050;
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall) hold++;
            @(posedge clk);
            #1;
        end
        chk("hang_stall_cycles", 32'(hold), 32'd100);
        chk("hang_dmem_valid", 32'(dmem_valid), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        req_r_en = 1'b0;
        #1;
        chk("hang_reset_valid", 32'(dmem_valid), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
